edge_check_monitor: RTL and testbench

- Synthesizable, multi-channel, parametrised edge-occurrence checker. It is the hardware successor to the simulation-only "$rose on every clock" property.
- Each channel watches one single-bit signal for a selected edge type. It flags a failure whenever no qualifying edge arrives within a programmable window of sampled cycles.
- It keeps sticky failure flags and saturating failure counters.
- It sits beside the DUT in emulation/FPGA builds, where SV assertions are unavailable.

---
 rtl/edge_check_monitor.sv | 137 +++++++++++++
 tb/tb_edge_check_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_check_monitor.sv
// Multi-channel edge-occurrence checker: flags any channel that goes a full window of
// samples without a qualifying edge, with sticky flags and saturating failure counters.
module edge_check_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MAX_WIN = 16,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [NUM_CH-1:0]         sig_in,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic [$clog2(MAX_WIN+1)-1:0] win,
  output logic [NUM_CH-1:0]         edge_o,
  output logic [NUM_CH-1:0]         fail_o,
  output logic [NUM_CH-1:0]         sticky_o,
  output logic [NUM_CH*CNT_W-1:0]   fail_cnt_o
);

  localparam int WIN_W = $clog2(MAX_WIN + 1);
  localparam logic [WIN_W-1:0] MAX_WIN_L = WIN_W'(MAX_WIN);
  localparam logic [WIN_W-1:0] TIMER_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, CHECK} state_t;

  logic [WIN_W-1:0]  win_eff;
  logic [NUM_CH-1:0] prev_reg;

  always_comb begin
    win_eff = (win > MAX_WIN_L) ? MAX_WIN_L : win;
  end

  // The previous sample tracks the input unconditionally so re-enabling never sees a stale edge.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_reg <= '0;
    else        prev_reg <= sig_in;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [WIN_W-1:0] timer_reg, timer_next;
      logic             edge_reg, edge_next;
      logic             fail_reg, fail_next;
      logic             sticky_reg, sticky_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_base;
      logic [1:0]       ch_mode;
      logic             cur, prv, qual, active, expire;
      logic [WIN_W:0]   timer_inc;

      assign ch_mode = mode[2*gi +: 2];
      assign cur     = sig_in[gi];
      assign prv     = prev_reg[gi];
      assign active  = en && (ch_mode != 2'b11);

      always_comb begin
        qual = 1'b0;
        case (ch_mode)
          2'b00:   qual = !prv && cur;
          2'b01:   qual = prv && !cur;
          2'b10:   qual = prv ^ cur;
          default: qual = 1'b0;
        endcase
      end

      // >= rather than == so a window shrunk below the running timer still expires.
      assign timer_inc = {1'b0, timer_reg} + {1'b0, TIMER_ONE};
      assign expire    = (win_eff != '0) && (timer_inc >= {1'b0, win_eff});

      always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        edge_next  = 1'b0;
        fail_next  = 1'b0;
        case (state_reg)
          IDLE, CHECK: begin
            if (!active) begin
              state_next = IDLE;
              timer_next = '0;
            end else begin
              state_next = CHECK;
              if (qual) begin
                edge_next  = 1'b1;
                timer_next = '0;
              end else if (expire) begin
                fail_next  = 1'b1;
                timer_next = '0;
              end else if (win_eff == '0) begin
                timer_next = '0;
              end else begin
                timer_next = timer_inc[WIN_W-1:0];
              end
            end
          end
          default: begin
            state_next = IDLE;
            timer_next = '0;
          end
        endcase
      end

      // A clear lands before a same-cycle failure, so that failure is still recorded.
      always_comb begin
        cnt_base    = clr ? '0 : cnt_reg;
        cnt_next    = (fail_next && (cnt_base != CNT_MAX)) ? cnt_base + CNT_ONE : cnt_base;
        sticky_next = clr ? fail_next : (sticky_reg | fail_next);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg  <= IDLE;
          timer_reg  <= '0;
          edge_reg   <= 1'b0;
          fail_reg   <= 1'b0;
          sticky_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          state_reg  <= state_next;
          timer_reg  <= timer_next;
          edge_reg   <= edge_next;
          fail_reg   <= fail_next;
          sticky_reg <= sticky_next;
          cnt_reg    <= cnt_next;
        end
      end

      assign edge_o[gi]                    = edge_reg;
      assign fail_o[gi]                    = fail_reg;
      assign sticky_o[gi]                  = sticky_reg;
      assign fail_cnt_o[CNT_W*gi +: CNT_W] = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_edge_check_monitor.sv
// Randomised and directed bench for edge_check_monitor, scored against a run-length
// model of each channel kept in plain integers.
module tb_edge_check_monitor;
  localparam int NUM_CH  = 4;
  localparam int MAX_WIN = 16;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = $clog2(MAX_WIN + 1);
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, en, clr;
  logic [NUM_CH-1:0]       sig_in;
  logic [2*NUM_CH-1:0]     mode;
  logic [WIN_W-1:0]        win;
  logic [NUM_CH-1:0]       edge_o, fail_o, sticky_o;
  logic [NUM_CH*CNT_W-1:0] fail_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: samples since last edge/restart, last sample, flags and counts.
  int run_len [NUM_CH];
  bit m_prev  [NUM_CH];
  bit m_sticky[NUM_CH];
  int m_cnt   [NUM_CH];
  bit m_edge  [NUM_CH];
  bit m_fail  [NUM_CH];

  edge_check_monitor #(.NUM_CH(NUM_CH), .MAX_WIN(MAX_WIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sig_in(sig_in), .mode(mode),
    .win(win), .edge_o(edge_o), .fail_o(fail_o), .sticky_o(sticky_o),
    .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_sample();
    int  w;
    int  md;
    bit  cur, hit;
    w = (int'(win) > MAX_WIN) ? MAX_WIN : int'(win);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cur = sig_in[ch];
      md  = int'(mode[2*ch +: 2]);
      m_edge[ch] = 0;
      m_fail[ch] = 0;
      if (!rst_n) begin
        run_len[ch] = 0; m_prev[ch] = 0; m_sticky[ch] = 0; m_cnt[ch] = 0;
        continue;
      end
      if (md == 0)      hit = (m_prev[ch] == 0) && (cur == 1);
      else if (md == 1) hit = (m_prev[ch] == 1) && (cur == 0);
      else if (md == 2) hit = (m_prev[ch] != cur);
      else              hit = 0;
      if (clr) begin
        m_sticky[ch] = 0;
        m_cnt[ch]    = 0;
      end
      if (!en || md == 3) begin
        run_len[ch] = 0;
      end else if (hit) begin
        m_edge[ch]  = 1;
        run_len[ch] = 0;
      end else if (w != 0 && run_len[ch] + 1 >= w) begin
        m_fail[ch]   = 1;
        m_sticky[ch] = 1;
        if (m_cnt[ch] < CNT_SAT) m_cnt[ch]++;
        run_len[ch]  = 0;
      end else begin
        run_len[ch] = (w == 0) ? 0 : run_len[ch] + 1;
      end
      m_prev[ch] = cur;
    end
  endtask

  task automatic step(input string tag);
    logic [NUM_CH-1:0]       e, f, s;
    logic [NUM_CH*CNT_W-1:0] c;
    @(posedge clk);
    model_sample();
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e[ch] = m_edge[ch];
      f[ch] = m_fail[ch];
      s[ch] = m_sticky[ch];
      c[CNT_W*ch +: CNT_W] = CNT_W'(m_cnt[ch]);
    end
    check_val({tag, "_edge"},   64'(edge_o),     64'(e));
    check_val({tag, "_fail"},   64'(fail_o),     64'(f));
    check_val({tag, "_sticky"}, 64'(sticky_o),   64'(s));
    check_val({tag, "_cnt"},    64'(fail_cnt_o), 64'(c));
    $display("%0t %s rst_n=%b en=%b clr=%b sig=%b mode=%h win=%0d edge=%b fail=%b sticky=%b cnt=%h",
             $time, tag, rst_n, en, clr, sig_in, mode, win, edge_o, fail_o, sticky_o, fail_cnt_o);
  endtask

  initial begin
    int fails_seen;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sig_in = '0; mode = 8'hFF; win = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      run_len[ch] = 0; m_prev[ch] = 0; m_sticky[ch] = 0; m_cnt[ch] = 0;
    end
    step("reset");
    step("reset");
    check_val("reset_cnt", 64'(fail_cnt_o), 64'd0);

    // 1: rise on ch0 with W=1, input held high from the first sample
    rst_n = 1'b1; en = 1'b1; mode = 8'hFC; win = 5'd1; sig_in = 4'b0001;
    step("t1");
    check_val("t1_first_edge", 64'(edge_o[0]), 64'd1);
    for (int k = 0; k < 5; k++) step("t1");
    check_val("t1_cnt5", 64'(fail_cnt_o[7:0]), 64'd5);
    check_val("t1_sticky", 64'(sticky_o[0]), 64'd1);

    // 2: either-edge on ch1, W=4, toggle period 3 then 5
    mode = 8'hFB; win = 5'd4; fails_seen = 0;
    for (int k = 0; k < 24; k++) begin
      step("t2p3");
      fails_seen += int'(fail_o[1]);
      if (k % 3 == 2) sig_in[1] = ~sig_in[1];
    end
    check_val("t2_no_fail_p3", 64'(fails_seen), 64'd0);
    check_val("t2_cnt_p3", 64'(fail_cnt_o[15:8]), 64'd0);
    fails_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step("t2p5");
      fails_seen += int'(fail_o[1]);
      if (k % 5 == 4) sig_in[1] = ~sig_in[1];
    end
    check_val("t2_fail_p5", 64'(fails_seen > 0), 64'd1);

    // 3: fall on ch2 held low, counter saturation and clear on a fail cycle
    mode = 8'hDF; win = 5'd1; sig_in[2] = 1'b0;
    for (int k = 0; k < 300; k++) step("t3");
    check_val("t3_sat", 64'(fail_cnt_o[23:16]), 64'd255);
    check_val("t3_still_fail", 64'(fail_o[2]), 64'd1);
    clr = 1'b1;
    step("t3clr");
    clr = 1'b0;
    check_val("t3_clr_cnt", 64'(fail_cnt_o[23:16]), 64'd1);
    check_val("t3_clr_sticky", 64'(sticky_o[2]), 64'd1);

    // 4: rise on ch3, W=3, edge exactly at expiry, then disable and re-enable
    mode = 8'h3F; win = 5'd3; sig_in[3] = 1'b0;
    step("t4"); step("t4");
    sig_in[3] = 1'b1;
    step("t4edge");
    check_val("t4_edge_wins", 64'({edge_o[3], fail_o[3]}), 64'b10);
    step("t4"); step("t4"); step("t4");
    check_val("t4_restart_fail", 64'(fail_o[3]), 64'd1);
    mode = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      step("t4off");
      check_val("t4_off_quiet", 64'({edge_o, fail_o}), 64'd0);
    end
    mode = 8'h3F;
    step("t4on"); step("t4on");
    check_val("t4_not_yet", 64'(fail_o[3]), 64'd0);
    step("t4on");
    check_val("t4_fail_at3", 64'(fail_o[3]), 64'd1);

    // 5: rise while disabled is not reported on re-enable; reset mid-window
    mode = 8'hFC; win = 5'd8; sig_in = '0;
    step("t5"); step("t5");
    en = 1'b0; sig_in[0] = 1'b1;
    step("t5off");
    en = 1'b1;
    step("t5on");
    check_val("t5_no_stale_edge", 64'(edge_o[0]), 64'd0);
    step("t5"); step("t5");
    rst_n = 1'b0;
    step("t5rst");
    check_val("t5_rst_outputs", 64'({edge_o, fail_o, sticky_o}), 64'd0);
    check_val("t5_rst_cnt", 64'(fail_cnt_o), 64'd0);
    rst_n = 1'b1;

    // 6: W=0, all channels rise, random inputs
    win = 5'd0; mode = 8'h00; en = 1'b1; fails_seen = 0;
    for (int k = 0; k < 200; k++) begin
      sig_in = NUM_CH'($urandom);
      step("t6");
      fails_seen += int'(fail_o != '0);
    end
    check_val("t6_no_fail", 64'(fails_seen), 64'd0);

    // 7: everything random, including windows beyond MAX_WIN
    for (int k = 0; k < 400; k++) begin
      if (k % 8 == 0) begin
        mode = 8'($urandom);
        win  = WIN_W'($urandom_range(0, 31));
      end
      en     = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 19) == 0);
      sig_in = (k % 2 == 0) ? NUM_CH'($urandom) : sig_in;
      step("t7");
    end
    clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
